// File: rtl/rs_pkg.sv
// Shared field defaults, controller state encoding and symbol type for the RS key-equation solver.
package rs_pkg;

    localparam int          RS_M         = 10;
    localparam int          RS_T         = 15;
    localparam logic [10:0] RS_PRIM_POLY = 11'h409;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BM    = 2'd1,
        OMEGA = 2'd2,
        DONE  = 2'd3
    } kes_state_t;

    typedef logic [RS_M-1:0] sym_t;

endpackage

// File: rtl/rs_dec_kes_ribm_if.sv
// Syndrome-in / locator-and-evaluator-out handshake bundle of the key-equation solver.
interface rs_dec_kes_ribm_if
    import rs_pkg::*;
#(
    parameter int M  = RS_M,
    parameter int T  = RS_T,
    parameter int CW = $clog2(T + 1)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*T*M-1:0]     in_syn;
    logic                 out_valid;
    logic                 out_ready;
    logic [(T+1)*M-1:0]   lambda;
    logic [T*M-1:0]       omega;
    logic [CW-1:0]        num_err;
    logic                 fail;

    modport master (
        output in_valid, in_syn, out_ready,
        input  in_ready, out_valid, lambda, omega, num_err, fail
    );

    modport slave (
        input  in_valid, in_syn, out_ready,
        output in_ready, out_valid, lambda, omega, num_err, fail
    );

endinterface

// File: rtl/gf_mul_p.sv
// Combinational GF(2^M) multiplier: shift-and-add with reduction modulo PRIM_POLY.
module gf_mul_p
    import rs_pkg::*;
#(
    parameter int         M         = RS_M,
    parameter logic [M:0] PRIM_POLY = RS_PRIM_POLY
) (
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    output logic [M-1:0] p_o
);

    logic [M-1:0] acc;
    logic [M-1:0] sh;

    always_comb begin
        acc = '0;
        sh  = a_i;
        for (int i = 0; i < M; i++) begin
            if (b_i[i]) acc = acc ^ sh;
            // multiply by alpha; the x^M term folds back through the generator
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PRIM_POLY[M-1:0] : '0);
        end
        p_o = acc;
    end

endmodule

// File: rtl/rs_dec_kes_ribm.sv
// Inversionless Berlekamp-Massey key-equation solver producing Lambda(x) and Omega(x).
// Optional all-zero-syndrome shortcut enabled by defining RS_KES_ZERO_BYPASS_EN.
module rs_dec_kes_ribm
    import rs_pkg::*;
#(
    parameter int         M         = RS_M,
    parameter int         T         = RS_T,
    parameter logic [M:0] PRIM_POLY = RS_PRIM_POLY,
    parameter int         CW        = $clog2(T + 1)
) (
    input  logic             clk,
    input  logic             rst,
    rs_dec_kes_ribm_if.slave bus
);

    localparam int NS = 2 * T;
    localparam int KW = $clog2(NS + 1);

    typedef logic [M-1:0] gsym_t;

    kes_state_t    state_q;
    logic [KW-1:0] cnt_q;
    logic [KW-1:0] l_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          fail_q;
    logic [CW-1:0] nerr_q;
    gsym_t         lam_out_q [T+1];
    gsym_t         omega_q   [T];

    gsym_t         syn_q   [NS];
    gsym_t         lam_q   [T+1];
    gsym_t         b_q     [T+1];
    gsym_t         gamma_q;

    gsym_t         win   [T+1];
    gsym_t         xb    [T+1];
    gsym_t         p_del [T+1];
    gsym_t         p_gam [T+1];
    gsym_t         p_b   [T+1];
    gsym_t         lam_d [T+1];
    gsym_t         delta;
    logic          upd;
    logic          xfer;
    logic          byp;
    logic          lam_nz;
    logic [KW-1:0] deg_c;

    function automatic logic [CW-1:0] sat_nerr(input logic [KW-1:0] l);
        return (int'(l) > T) ? CW'(T) : CW'(l);
    endfunction

    assign xfer = bus.in_valid && in_ready_q && (state_q == IDLE);

`ifdef RS_KES_ZERO_BYPASS_EN
    assign byp = ~|bus.in_syn;
`else
    assign byp = 1'b0;
`endif

    // Syndrome window S_{cnt+1-j}; the same indexing serves delta in BM and omega_i in OMEGA.
    always_comb begin
        for (int j = 0; j <= T; j++) begin
            win[j] = '0;
            for (int s = 1; s <= NS; s++) begin
                if (int'(cnt_q) + 1 - j == s) win[j] = syn_q[s-1];
            end
        end
        xb[0] = '0;
        for (int j = 1; j <= T; j++) xb[j] = b_q[j-1];
    end

    for (genvar j = 0; j <= T; j++) begin : g_mul
        gf_mul_p #(.M(M), .PRIM_POLY(PRIM_POLY)) u_del (
            .a_i(lam_q[j]), .b_i(win[j]), .p_o(p_del[j])
        );
        gf_mul_p #(.M(M), .PRIM_POLY(PRIM_POLY)) u_gam (
            .a_i(gamma_q), .b_i(lam_q[j]), .p_o(p_gam[j])
        );
        gf_mul_p #(.M(M), .PRIM_POLY(PRIM_POLY)) u_b (
            .a_i(delta), .b_i(xb[j]), .p_o(p_b[j])
        );
    end

    always_comb begin
        delta = '0;
        for (int j = 0; j <= T; j++) delta = delta ^ p_del[j];
    end

    always_comb begin
        for (int j = 0; j <= T; j++) lam_d[j] = p_gam[j] ^ p_b[j];
    end

    assign upd = (delta != '0) && (2 * int'(l_q) <= int'(cnt_q));

    always_comb begin
        deg_c  = '0;
        lam_nz = 1'b0;
        for (int j = 0; j <= T; j++) begin
            if (lam_q[j] != '0) begin
                deg_c  = KW'(j);
                lam_nz = 1'b1;
            end
        end
    end

    // Working polynomials: loaded on transfer, advanced once per BM iteration.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int s = 0; s < NS; s++) syn_q[s] <= bus.in_syn[s*M +: M];
            for (int j = 0; j <= T; j++) begin
                lam_q[j] <= (j == 0) ? gsym_t'(1) : '0;
                b_q[j]   <= (j == 0) ? gsym_t'(1) : '0;
            end
            gamma_q <= gsym_t'(1);
        end else if (state_q == BM) begin
            for (int j = 0; j <= T; j++) begin
                lam_q[j] <= lam_d[j];
                b_q[j]   <= upd ? lam_q[j] : xb[j];
            end
            if (upd) gamma_q <= delta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            fail_q      <= 1'b0;
            nerr_q      <= '0;
            for (int j = 0; j <= T; j++) lam_out_q[j] <= '0;
            for (int i = 0; i < T; i++) omega_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        l_q        <= '0;
                        in_ready_q <= 1'b0;
                        for (int i = 0; i < T; i++) omega_q[i] <= '0;
                        // zero syndromes skip straight to the result-latching step
                        cnt_q      <= byp ? KW'(T) : '0;
                        state_q    <= byp ? OMEGA : BM;
                    end
                end
                BM: begin
                    if (upd) l_q <= cnt_q + KW'(1) - l_q;
                    if (cnt_q == KW'(NS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= OMEGA;
                    end else begin
                        cnt_q <= cnt_q + KW'(1);
                    end
                end
                OMEGA: begin
                    if (cnt_q == KW'(T)) begin
                        for (int j = 0; j <= T; j++) lam_out_q[j] <= lam_q[j];
                        nerr_q      <= sat_nerr(l_q);
                        fail_q      <= (int'(l_q) > T) || !lam_nz || (deg_c != l_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        for (int i = 0; i < T; i++) begin
                            if (cnt_q == KW'(i)) omega_q[i] <= delta;
                        end
                        cnt_q <= cnt_q + KW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.num_err   = nerr_q;
    assign bus.fail      = fail_q;

    for (genvar j = 0; j <= T; j++) begin : g_lam_o
        assign bus.lambda[j*M +: M] = lam_out_q[j];
    end

    for (genvar i = 0; i < T; i++) begin : g_om_o
        assign bus.omega[i*M +: M] = omega_q[i];
    end

endmodule

// File: tb/tb_rs_dec_kes_ribm.sv
// Bench for rs_dec_kes_ribm: directed syndrome blocks plus random error patterns against a root-based model.
module tb_rs_dec_kes_ribm;
    import rs_pkg::*;

    localparam int M   = RS_M;
    localparam int T   = RS_T;
    localparam int N   = (1 << M) - 1;
    localparam int LAT = 3 * T + 1;
`ifdef RS_KES_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 3 * T + 1;
`endif

    typedef logic [255:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    sym_t exp_t [N];
    int   log_t [N+1];
    sym_t syn_s [2*T];
    sym_t lref  [T+2];
    sym_t oref  [T];
    int   pos_q [$];
    sym_t mag_q [$];

    rs_dec_kes_ribm_if #(.M(M), .T(T)) bus ();

    rs_dec_kes_ribm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic sym_t gmul(input sym_t a, input sym_t b);
        if (a == 0 || b == 0) return '0;
        return exp_t[(log_t[a] + log_t[b]) % N];
    endfunction

    function automatic sym_t dut_lam(input int i);
        return bus.lambda[i*M +: M];
    endfunction

    function automatic sym_t dut_om(input int i);
        return bus.omega[i*M +: M];
    endfunction

    task automatic chk(input string tag, input vec_t obs, input vec_t expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_model();
        sym_t s;
        for (int j = 1; j <= 2 * T; j++) begin
            s = '0;
            foreach (pos_q[k]) s = s ^ gmul(mag_q[k], exp_t[(j * pos_q[k]) % N]);
            syn_s[j-1] = s;
        end
        for (int i = 0; i < T + 2; i++) lref[i] = '0;
        lref[0] = sym_t'(1);
        foreach (pos_q[k]) begin
            for (int i = T + 1; i >= 1; i--) lref[i] = lref[i] ^ gmul(exp_t[pos_q[k]], lref[i-1]);
        end
        for (int i = 0; i < T; i++) begin
            oref[i] = '0;
            for (int j = 0; j <= i; j++) oref[i] = oref[i] ^ gmul(lref[j], syn_s[i-j]);
        end
    endtask

    task automatic make_errors(input int v);
        int p;
        bit dup;
        pos_q.delete();
        mag_q.delete();
        while (pos_q.size() < v) begin
            p   = int'($urandom_range(N - 1, 0));
            dup = 1'b0;
            foreach (pos_q[k]) if (pos_q[k] == p) dup = 1'b1;
            if (!dup) begin
                pos_q.push_back(p);
                mag_q.push_back(sym_t'($urandom_range(N, 1)));
            end
        end
        build_model();
    endtask

    task automatic pack_syn();
        for (int s = 0; s < 2 * T; s++) bus.in_syn[s*M +: M] = syn_s[s];
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, vec_t'(lat), vec_t'(exp_lat));
    endtask

    task automatic send(input string tag, input int exp_lat);
        @(negedge clk);
        chk({tag, ".in_ready"}, vec_t'(bus.in_ready), vec_t'(1));
        pack_syn();
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_valid(tag, exp_lat);
    endtask

    task automatic accept(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".vld_drop"}, vec_t'(bus.out_valid), vec_t'(0));
        chk({tag, ".rdy_back"}, vec_t'(bus.in_ready), vec_t'(1));
    endtask

    task automatic check_exact(input string tag, input logic [(T+1)*M-1:0] elam,
                               input logic [T*M-1:0] eom, input int ne, input int fl);
        chk({tag, ".lambda"},  vec_t'(bus.lambda),  vec_t'(elam));
        chk({tag, ".omega"},   vec_t'(bus.omega),   vec_t'(eom));
        chk({tag, ".num_err"}, vec_t'(bus.num_err), vec_t'(ne));
        chk({tag, ".fail"},    vec_t'(bus.fail),    vec_t'(fl));
    endtask

    // Lambda is only defined up to a common scale; its constant term fixes that scale.
    task automatic check_model(input string tag, input int v);
        sym_t c;
        sym_t ev;
        sym_t xinv;
        int   roots;
        c = dut_lam(0);
        roots = 0;
        foreach (pos_q[k]) begin
            xinv = exp_t[(N - pos_q[k]) % N];
            ev = '0;
            for (int i = T; i >= 0; i--) ev = gmul(ev, xinv) ^ dut_lam(i);
            if (v <= T) chk($sformatf("%s.root%0d", tag, k), vec_t'(ev), vec_t'(0));
            if (ev == 0) roots++;
        end
        if (v <= T) begin
            chk({tag, ".fail"},    vec_t'(bus.fail),    vec_t'(0));
            chk({tag, ".num_err"}, vec_t'(bus.num_err), vec_t'(v));
            chk({tag, ".lam0_nz"}, vec_t'(c != 0),      vec_t'(1));
            for (int i = 1; i <= T; i++)
                chk($sformatf("%s.lam%0d", tag, i), vec_t'(dut_lam(i)), vec_t'(gmul(c, lref[i])));
            for (int i = 0; i < T; i++)
                chk($sformatf("%s.om%0d", tag, i), vec_t'(dut_om(i)), vec_t'(gmul(c, oref[i])));
        end else begin
            chk({tag, ".overflow_flag"}, vec_t'((bus.fail === 1'b1) || (roots < v)), vec_t'(1));
        end
    endtask

    logic [(T+1)*M-1:0] e_lam;
    logic [T*M-1:0]     e_om;
    logic [(T+1)*M-1:0] ones_lam;
    logic [T*M-1:0]     ones_om;

    initial begin
        int v;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_syn    = '0;

        exp_t[0] = sym_t'(1);
        for (int i = 1; i < N; i++) begin
            v = int'(exp_t[i-1]) * 2;
            if (v > N) v = v ^ 'h409;
            exp_t[i] = sym_t'(v);
        end
        for (int i = 0; i <= N; i++) log_t[i] = 0;
        for (int i = 0; i < N; i++) log_t[exp_t[i]] = i;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.in_ready",  vec_t'(bus.in_ready),  vec_t'(1));
        chk("reset.out_valid", vec_t'(bus.out_valid), vec_t'(0));
        check_exact("reset", '0, '0, 0, 0);

        // all-zero syndromes: no errors
        for (int s = 0; s < 2 * T; s++) syn_s[s] = '0;
        e_lam = '0;
        e_lam[0 +: M] = sym_t'(1);
        send("zero", ZLAT);
        check_exact("zero", e_lam, '0, 0, 0);
        accept("zero");

        // all S_j = 1: single unit error at position 0
        for (int s = 0; s < 2 * T; s++) syn_s[s] = sym_t'(1);
        ones_lam = '0;
        ones_lam[0 +: M] = sym_t'(1);
        ones_lam[M +: M] = sym_t'(1);
        ones_om = '0;
        ones_om[0 +: M] = sym_t'(1);
        send("ones", LAT);
        check_exact("ones", ones_lam, ones_om, 1, 0);
        accept("ones");

        // only S_1 set: degree of Lambda disagrees with L
        for (int s = 0; s < 2 * T; s++) syn_s[s] = '0;
        syn_s[0] = sym_t'(1);
        e_om = '0;
        e_om[0 +: M] = sym_t'(1);
        send("s1only", LAT);
        check_exact("s1only", e_lam, e_om, 1, 1);
        accept("s1only");

        for (int nv = 1; nv <= T; nv++) begin
            make_errors(nv);
            send($sformatf("rand%0d", nv), LAT);
            check_model($sformatf("rand%0d", nv), nv);
            accept($sformatf("rand%0d", nv));
        end

        make_errors(T + 1);
        send("over", LAT);
        check_model("over", T + 1);
        accept("over");

        // back-pressure in DONE with a new block waiting on the input
        for (int s = 0; s < 2 * T; s++) syn_s[s] = sym_t'(1);
        send("hold", LAT);
        make_errors(5);
        pack_syn();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d.in_ready", c),  vec_t'(bus.in_ready),  vec_t'(0));
            chk($sformatf("hold%0d.out_valid", c), vec_t'(bus.out_valid), vec_t'(1));
            chk($sformatf("hold%0d.lambda", c),    vec_t'(bus.lambda),    vec_t'(ones_lam));
            chk($sformatf("hold%0d.omega", c),     vec_t'(bus.omega),     vec_t'(ones_om));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release.out_valid", vec_t'(bus.out_valid), vec_t'(0));
        chk("release.in_ready",  vec_t'(bus.in_ready),  vec_t'(1));
        @(posedge clk);
        #1;
        chk("release.taken", vec_t'(bus.in_ready), vec_t'(0));
        bus.in_valid = 1'b0;
        wait_valid("after_hold", LAT);
        check_model("after_hold", 5);
        accept("after_hold");

        // reset in the middle of BM
        make_errors(9);
        @(negedge clk);
        pack_syn();
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", vec_t'(bus.out_valid), vec_t'(0));
        chk("midrst.in_ready",  vec_t'(bus.in_ready),  vec_t'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("postrst.in_ready",  vec_t'(bus.in_ready),  vec_t'(1));
        chk("postrst.out_valid", vec_t'(bus.out_valid), vec_t'(0));
        chk("postrst.lambda",    vec_t'(bus.lambda),    vec_t'(0));
        send("after_rst", LAT);
        check_model("after_rst", 9);
        accept("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
